// File: rtl/fc_argmax_if.sv
// Score-stream and result bundle between the fully-connected stage,
// the argmax classifier and the top-level result register.
interface fc_argmax_if #(
  parameter int DATA_WIDTH = 12,
  parameter int IDX_WIDTH  = 4
);
  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         valid_out;
  logic        [IDX_WIDTH-1:0]  class_out;
  logic signed [DATA_WIDTH-1:0] best_score;
  logic        [IDX_WIDTH-1:0]  second_idx;
  logic signed [DATA_WIDTH-1:0] second_score;
  logic        [DATA_WIDTH:0]   margin;
  logic        [IDX_WIDTH-1:0]  frame_count;

  // Score producer side: drives the stream, observes the result.
  modport master (
    output valid_in, data_in,
    input  valid_out, class_out, best_score, second_idx, second_score,
           margin, frame_count
  );

  // Classifier side: consumes the stream, produces the result.
  modport slave (
    input  valid_in, data_in,
    output valid_out, class_out, best_score, second_idx, second_score,
           margin, frame_count
  );
endinterface

// File: rtl/fc_argmax_classifier.sv
// Final CNN stage: tracks best and second-best class scores across each
// frame of NUM_CLASSES scores and publishes a one-cycle result strobe
// with predicted class, both scores and the confidence margin.
module fc_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 12,
  parameter int IDX_WIDTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fc_argmax_if.slave   bus
);

  localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic        [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);

  // Best minus second in one extra bit so full-scale spreads cannot wrap.
  function automatic logic [DATA_WIDTH:0] calc_margin(
    input logic signed [DATA_WIDTH-1:0] hi,
    input logic signed [DATA_WIDTH-1:0] lo
  );
    logic [DATA_WIDTH:0] diff;
    diff = {hi[DATA_WIDTH-1], hi} - {lo[DATA_WIDTH-1], lo};
    return diff;
  endfunction

  logic        [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] run_best_q, run_best_d;
  logic        [IDX_WIDTH-1:0]  run_best_idx_q, run_best_idx_d;
  logic signed [DATA_WIDTH-1:0] run_second_q, run_second_d;
  logic        [IDX_WIDTH-1:0]  run_second_idx_q, run_second_idx_d;

  logic                         valid_out_q, valid_out_d;
  logic        [IDX_WIDTH-1:0]  class_out_q, class_out_d;
  logic signed [DATA_WIDTH-1:0] best_score_q, best_score_d;
  logic        [IDX_WIDTH-1:0]  second_idx_q, second_idx_d;
  logic signed [DATA_WIDTH-1:0] second_score_q, second_score_d;
  logic        [DATA_WIDTH:0]   margin_q, margin_d;
  logic        [IDX_WIDTH-1:0]  frame_count_q, frame_count_d;

  // Running best/second update and frame-completion result capture.
  always_comb begin
    idx_d            = idx_q;
    run_best_d       = run_best_q;
    run_best_idx_d   = run_best_idx_q;
    run_second_d     = run_second_q;
    run_second_idx_d = run_second_idx_q;
    valid_out_d      = 1'b0;
    class_out_d      = class_out_q;
    best_score_d     = best_score_q;
    second_idx_d     = second_idx_q;
    second_score_d   = second_score_q;
    margin_d         = margin_q;
    frame_count_d    = frame_count_q;

    if (bus.valid_in) begin
      if (idx_q == '0) begin
        // First score of a frame seeds best; second starts at most negative.
        run_best_d       = bus.data_in;
        run_best_idx_d   = '0;
        run_second_d     = SCORE_MIN;
        run_second_idx_d = '0;
      end else if (bus.data_in > run_best_q) begin
        run_second_d     = run_best_q;
        run_second_idx_d = run_best_idx_q;
        run_best_d       = bus.data_in;
        run_best_idx_d   = idx_q;
      end else if (bus.data_in > run_second_q) begin
        // Ties with best land here, so the lower index keeps first place.
        run_second_d     = bus.data_in;
        run_second_idx_d = idx_q;
      end

      if (idx_q == LAST_IDX) begin
        idx_d          = '0;
        valid_out_d    = 1'b1;
        class_out_d    = run_best_idx_d;
        best_score_d   = run_best_d;
        second_idx_d   = run_second_idx_d;
        second_score_d = run_second_d;
        margin_d       = calc_margin(run_best_d, run_second_d);
        frame_count_d  = frame_count_q + IDX_WIDTH'(1);
      end else begin
        idx_d = idx_q + IDX_WIDTH'(1);
      end
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q            <= '0;
      run_best_q       <= '0;
      run_best_idx_q   <= '0;
      run_second_q     <= SCORE_MIN;
      run_second_idx_q <= '0;
      valid_out_q      <= 1'b0;
      class_out_q      <= '0;
      best_score_q     <= '0;
      second_idx_q     <= '0;
      second_score_q   <= '0;
      margin_q         <= '0;
      frame_count_q    <= '0;
    end else begin
      idx_q            <= idx_d;
      run_best_q       <= run_best_d;
      run_best_idx_q   <= run_best_idx_d;
      run_second_q     <= run_second_d;
      run_second_idx_q <= run_second_idx_d;
      valid_out_q      <= valid_out_d;
      class_out_q      <= class_out_d;
      best_score_q     <= best_score_d;
      second_idx_q     <= second_idx_d;
      second_score_q   <= second_score_d;
      margin_q         <= margin_d;
      frame_count_q    <= frame_count_d;
    end
  end

  assign bus.valid_out    = valid_out_q;
  assign bus.class_out    = class_out_q;
  assign bus.best_score   = best_score_q;
  assign bus.second_idx   = second_idx_q;
  assign bus.second_score = second_score_q;
  assign bus.margin       = margin_q;
  assign bus.frame_count  = frame_count_q;

endmodule
